// File: rtl/rename_alloc_if.sv
// Signal bundle between the rename stage and its decode, ROB and commit neighbours.
`timescale 1ns/1ps
interface rename_alloc_if #(
  parameter int unsigned ARCH_ADDRWIDTH = 5,
  parameter int unsigned PREG_ADDRWIDTH = 6,
  parameter int unsigned ROB_ADDRWIDTH  = 4
);
  localparam int unsigned NUM_ARCH         = 1 << ARCH_ADDRWIDTH;
  localparam int unsigned RENROB_DATAWIDTH = 1 + ARCH_ADDRWIDTH + 2 * PREG_ADDRWIDTH;

  // Global control and flush restore
  logic                               FREEZE;
  logic                               flush_IN;
  logic [NUM_ARCH*PREG_ADDRWIDTH-1:0] retRat_IN;

  // Decode handshake
  logic                      dec_valid_IN;
  logic                      dec_ready_OUT;
  logic [ARCH_ADDRWIDTH-1:0] dec_rs_IN;
  logic [ARCH_ADDRWIDTH-1:0] dec_rt_IN;
  logic [ARCH_ADDRWIDTH-1:0] dec_rd_IN;
  logic                      dec_writesReg_IN;

  // Renamed instruction
  logic                      ren_valid_OUT;
  logic [PREG_ADDRWIDTH-1:0] ren_ps_OUT;
  logic [PREG_ADDRWIDTH-1:0] ren_pt_OUT;
  logic [PREG_ADDRWIDTH-1:0] ren_pd_OUT;
  logic [ROB_ADDRWIDTH-1:0]  ren_robIdx_OUT;

  // ROB tail push
  logic                        tROB_pushReq_OUT;
  logic [RENROB_DATAWIDTH-1:0] tROB_pushData_OUT;
  logic                        fROB_full_IN;
  logic [ROB_ADDRWIDTH-1:0]    fROB_curTail_IN;

  // Commit feedback
  logic                      freeReq_IN;
  logic [PREG_ADDRWIDTH-1:0] freePreg_IN;
  logic                      commitAlloc_IN;

  modport slave (
    input  FREEZE, flush_IN, retRat_IN,
    input  dec_valid_IN, dec_rs_IN, dec_rt_IN, dec_rd_IN, dec_writesReg_IN,
    output dec_ready_OUT,
    output ren_valid_OUT, ren_ps_OUT, ren_pt_OUT, ren_pd_OUT, ren_robIdx_OUT,
    output tROB_pushReq_OUT, tROB_pushData_OUT,
    input  fROB_full_IN, fROB_curTail_IN,
    input  freeReq_IN, freePreg_IN, commitAlloc_IN
  );

  modport master (
    output FREEZE, flush_IN, retRat_IN,
    output dec_valid_IN, dec_rs_IN, dec_rt_IN, dec_rd_IN, dec_writesReg_IN,
    input  dec_ready_OUT,
    input  ren_valid_OUT, ren_ps_OUT, ren_pt_OUT, ren_pd_OUT, ren_robIdx_OUT,
    input  tROB_pushReq_OUT, tROB_pushData_OUT,
    output fROB_full_IN, fROB_curTail_IN,
    output freeReq_IN, freePreg_IN, commitAlloc_IN
  );
endinterface

// File: rtl/rename_alloc.sv
// Rename/dispatch: speculative RAT lookup, circular free-list allocation and ROB tail push.
`timescale 1ns/1ps
module rename_alloc #(
  parameter int unsigned ARCH_ADDRWIDTH   = 5,
  parameter int unsigned PREG_ADDRWIDTH   = 6,
  parameter int unsigned ROB_ADDRWIDTH    = 4,
  parameter int unsigned RENROB_DATAWIDTH = 1 + ARCH_ADDRWIDTH + 2 * PREG_ADDRWIDTH
) (
  input logic           CLK,
  input logic           RESET,
  rename_alloc_if.slave bus
);
  localparam int unsigned NUM_ARCH  = 1 << ARCH_ADDRWIDTH;
  localparam int unsigned NUM_PREG  = 1 << PREG_ADDRWIDTH;
  localparam int unsigned PTR_W     = PREG_ADDRWIDTH + 1;
  localparam int unsigned FREE_INIT = NUM_PREG - NUM_ARCH;

  // Speculative RAT and free list; pointers carry a wrap bit so count = tail - head
  logic [PREG_ADDRWIDTH-1:0] rat_q [NUM_ARCH];
  logic [PREG_ADDRWIDTH-1:0] rat_d [NUM_ARCH];
  logic [PREG_ADDRWIDTH-1:0] fl_q  [NUM_PREG];
  logic [PREG_ADDRWIDTH-1:0] fl_d  [NUM_PREG];
  logic [PTR_W-1:0]          head_q, head_d;
  logic [PTR_W-1:0]          tail_q, tail_d;
  logic [PTR_W-1:0]          ret_head_q, ret_head_d;

  logic                      ren_valid_q, ren_valid_d;
  logic [PREG_ADDRWIDTH-1:0] ren_ps_q, ren_ps_d;
  logic [PREG_ADDRWIDTH-1:0] ren_pt_q, ren_pt_d;
  logic [PREG_ADDRWIDTH-1:0] ren_pd_q, ren_pd_d;
  logic [ROB_ADDRWIDTH-1:0]  ren_rob_q, ren_rob_d;

  logic                        alloc_c;
  logic                        ready_c;
  logic                        accept_c;
  logic [PTR_W-1:0]            count_c;
  logic [PREG_ADDRWIDTH-1:0]   new_preg_c;
  logic [PREG_ADDRWIDTH-1:0]   old_preg_c;
  logic [RENROB_DATAWIDTH-1:0] push_data_c;

  // Handshake and ROB entry; a non-allocating entry keeps rd but carries no pregs
  always_comb begin
    count_c     = tail_q - head_q;
    alloc_c     = bus.dec_writesReg_IN && (bus.dec_rd_IN != '0);
    ready_c     = RESET && !bus.FREEZE && !bus.flush_IN && !bus.fROB_full_IN &&
                  (!alloc_c || (count_c != '0));
    accept_c    = bus.dec_valid_IN && ready_c;
    new_preg_c  = alloc_c ? fl_q[head_q[PREG_ADDRWIDTH-1:0]] : '0;
    old_preg_c  = alloc_c ? rat_q[bus.dec_rd_IN] : '0;
    push_data_c = '0;
    if (accept_c) begin
      push_data_c = {alloc_c, bus.dec_rd_IN, new_preg_c, old_preg_c};
    end
  end

  // Next state: commit feedback always lands; flush beats freeze beats accept
  always_comb begin
    rat_d       = rat_q;
    fl_d        = fl_q;
    head_d      = head_q;
    tail_d      = tail_q;
    ret_head_d  = ret_head_q;
    ren_valid_d = ren_valid_q;
    ren_ps_d    = ren_ps_q;
    ren_pt_d    = ren_pt_q;
    ren_pd_d    = ren_pd_q;
    ren_rob_d   = ren_rob_q;

    if (bus.commitAlloc_IN) begin
      ret_head_d = ret_head_q + PTR_W'(1);
    end
    if (bus.freeReq_IN) begin
      fl_d[tail_q[PREG_ADDRWIDTH-1:0]] = bus.freePreg_IN;
      tail_d = tail_q + PTR_W'(1);
    end

    if (bus.flush_IN) begin
      for (int unsigned i = 0; i < NUM_ARCH; i++) begin
        rat_d[i] = bus.retRat_IN[i*PREG_ADDRWIDTH +: PREG_ADDRWIDTH];
      end
      head_d      = ret_head_d;
      ren_valid_d = 1'b0;
    end else if (!bus.FREEZE) begin
      ren_valid_d = accept_c;
      if (accept_c) begin
        ren_ps_d  = rat_q[bus.dec_rs_IN];
        ren_pt_d  = rat_q[bus.dec_rt_IN];
        ren_pd_d  = new_preg_c;
        ren_rob_d = bus.fROB_curTail_IN;
        if (alloc_c) begin
          rat_d[bus.dec_rd_IN] = new_preg_c;
          head_d = head_q + PTR_W'(1);
        end
      end
    end
  end

  // State registers; reset gives identity RAT and free list of the upper pregs
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      for (int unsigned i = 0; i < NUM_ARCH; i++) begin
        rat_q[i] <= PREG_ADDRWIDTH'(i);
      end
      for (int unsigned i = 0; i < NUM_PREG; i++) begin
        fl_q[i] <= (i < FREE_INIT) ? PREG_ADDRWIDTH'(i + NUM_ARCH) : '0;
      end
      head_q      <= '0;
      tail_q      <= PTR_W'(FREE_INIT);
      ret_head_q  <= '0;
      ren_valid_q <= 1'b0;
      ren_ps_q    <= '0;
      ren_pt_q    <= '0;
      ren_pd_q    <= '0;
      ren_rob_q   <= '0;
    end else begin
      rat_q       <= rat_d;
      fl_q        <= fl_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      ret_head_q  <= ret_head_d;
      ren_valid_q <= ren_valid_d;
      ren_ps_q    <= ren_ps_d;
      ren_pt_q    <= ren_pt_d;
      ren_pd_q    <= ren_pd_d;
      ren_rob_q   <= ren_rob_d;
    end
  end

  assign bus.dec_ready_OUT     = ready_c;
  assign bus.tROB_pushReq_OUT  = accept_c;
  assign bus.tROB_pushData_OUT = push_data_c;
  assign bus.ren_valid_OUT     = ren_valid_q;
  assign bus.ren_ps_OUT        = ren_ps_q;
  assign bus.ren_pt_OUT        = ren_pt_q;
  assign bus.ren_pd_OUT        = ren_pd_q;
  assign bus.ren_robIdx_OUT    = ren_rob_q;

  // A free into a full list means commit returned a register twice
  a_no_free_overflow: assert property (@(posedge CLK) disable iff (!RESET)
    !(bus.freeReq_IN && (count_c == PTR_W'(FREE_INIT)) && !(accept_c && alloc_c)));

endmodule

// File: tb/tb_rename_alloc.sv
// Bench for rename_alloc: queue-based free-list model with a push/ren scoreboard.
`timescale 1ns/1ps
module tb_rename_alloc;
  localparam int unsigned AW = 5;
  localparam int unsigned PW = 6;
  localparam int unsigned RW = 4;
  localparam int unsigned DW = 1 + AW + 2 * PW;
  localparam int unsigned NA = 1 << AW;
  localparam int unsigned NP = 1 << PW;

  typedef struct packed {
    logic          v;
    logic [PW-1:0] ps;
    logic [PW-1:0] pt;
    logic [PW-1:0] pd;
    logic [RW-1:0] idx;
  } ren_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  rename_alloc_if #(.ARCH_ADDRWIDTH(AW), .PREG_ADDRWIDTH(PW), .ROB_ADDRWIDTH(RW)) bus ();

  rename_alloc #(.ARCH_ADDRWIDTH(AW), .PREG_ADDRWIDTH(PW), .ROB_ADDRWIDTH(RW),
                 .RENROB_DATAWIDTH(DW)) dut (
    .CLK  (clk),
    .RESET(rst_n),
    .bus  (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: free pregs in order, allocated-but-uncommitted pregs in order
  int   rat_m    [NA];
  int   retrat_m [NA];
  int   fq  [$];
  int   spq [$];
  logic [DW-1:0] push_q [$];
  ren_t ren_q [$];
  ren_t ren_m;
  bit   exp_ready;
  bit   mon_en = 1'b0;
  logic [DW-1:0] mon_pe;
  ren_t mon_re;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compare combinational push and registered ren outputs to queued expectations
  always @(negedge clk) begin
    if (mon_en) begin
      check("dec_ready", 64'(bus.dec_ready_OUT), 64'(exp_ready));
      check("push_req", 64'(bus.tROB_pushReq_OUT), 64'(push_q.size() > 0));
      if (push_q.size() > 0) begin
        mon_pe = push_q.pop_front();
        if (bus.tROB_pushReq_OUT) check("push_data", 64'(bus.tROB_pushData_OUT), 64'(mon_pe));
      end
      if (ren_q.size() > 0) begin
        mon_re = ren_q.pop_front();
        check("ren_valid", 64'(bus.ren_valid_OUT), 64'(mon_re.v));
        check("ren_ps", 64'(bus.ren_ps_OUT), 64'(mon_re.ps));
        check("ren_pt", 64'(bus.ren_pt_OUT), 64'(mon_re.pt));
        check("ren_pd", 64'(bus.ren_pd_OUT), 64'(mon_re.pd));
        check("ren_robIdx", 64'(bus.ren_robIdx_OUT), 64'(mon_re.idx));
      end else begin
        n_tests++;
        n_fail++;
        $display("FAIL ren_record: no expectation queued, got valid=%0b", bus.ren_valid_OUT);
      end
    end
  end

  // One cycle of stimulus: drive inputs, queue expectations, advance the model, wait for the edge
  task automatic drive(input bit v, input int rs, input int rt, input int rd, input bit wr,
                       input bit fz, input bit fl, input bit full,
                       input bit fr, input int fp, input bit cm, input int tail);
    bit alloc, acc;
    int np, op, tmp;
    bus.dec_valid_IN     = v;
    bus.dec_rs_IN        = AW'(rs);
    bus.dec_rt_IN        = AW'(rt);
    bus.dec_rd_IN        = AW'(rd);
    bus.dec_writesReg_IN = wr;
    bus.FREEZE           = fz;
    bus.flush_IN         = fl;
    bus.fROB_full_IN     = full;
    bus.fROB_curTail_IN  = RW'(tail);
    bus.freeReq_IN       = fr;
    bus.freePreg_IN      = PW'(fp);
    bus.commitAlloc_IN   = cm;
    for (int i = 0; i < NA; i++) bus.retRat_IN[i*PW +: PW] = PW'(retrat_m[i]);

    alloc     = wr && (rd != 0);
    exp_ready = !fz && !fl && !full && (!alloc || fq.size() != 0);
    acc       = v && exp_ready;
    np        = 0;
    if (acc && alloc) np = fq[0];
    op = alloc ? rat_m[rd] : 0;
    if (acc) push_q.push_back({alloc, AW'(rd), PW'(np), PW'(op)});

    if (fl) begin
      ren_m.v = 1'b0;
    end else if (!fz) begin
      if (acc) begin
        ren_m.v   = 1'b1;
        ren_m.ps  = PW'(rat_m[rs]);
        ren_m.pt  = PW'(rat_m[rt]);
        ren_m.pd  = PW'(np);
        ren_m.idx = RW'(tail);
      end else begin
        ren_m.v = 1'b0;
      end
    end
    ren_q.push_back(ren_m);

    if (cm) tmp = spq.pop_front();
    if (fl) begin
      for (int i = spq.size() - 1; i >= 0; i--) fq.push_front(spq[i]);
      spq.delete();
      rat_m = retrat_m;
    end else if (acc && alloc) begin
      tmp = fq.pop_front();
      spq.push_back(np);
      rat_m[rd] = np;
    end
    if (fr) fq.push_back(fp);

    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    mon_en = 1'b0;
    bus.dec_valid_IN = 1'b0; bus.dec_rs_IN = '0; bus.dec_rt_IN = '0; bus.dec_rd_IN = '0;
    bus.dec_writesReg_IN = 1'b0; bus.FREEZE = 1'b0; bus.flush_IN = 1'b0; bus.retRat_IN = '0;
    bus.fROB_full_IN = 1'b0; bus.fROB_curTail_IN = '0; bus.freeReq_IN = 1'b0;
    bus.freePreg_IN = '0; bus.commitAlloc_IN = 1'b0;
    rst_n = 1'b0;
    #3;
    check("rst_ready", 64'(bus.dec_ready_OUT), 64'(0));
    check("rst_push_req", 64'(bus.tROB_pushReq_OUT), 64'(0));
    check("rst_push_data", 64'(bus.tROB_pushData_OUT), 64'(0));
    check("rst_ren_valid", 64'(bus.ren_valid_OUT), 64'(0));
    check("rst_ren_pd", 64'(bus.ren_pd_OUT), 64'(0));
    check("rst_ren_robIdx", 64'(bus.ren_robIdx_OUT), 64'(0));
    for (int i = 0; i < NA; i++) begin
      rat_m[i]    = i;
      retrat_m[i] = i;
    end
    fq.delete();
    for (int p = NA; p < NP; p++) fq.push_back(p);
    spq.delete();
    push_q.delete();
    ren_q.delete();
    ren_m = '0;
    ren_q.push_back(ren_m);
    @(posedge clk);
    #1;
    rst_n  = 1'b1;
    mon_en = 1'b1;
  endtask

  initial begin
    bit v, wr, fz, fl, full, fr, cm;
    #2;
    do_reset();

    // Idle after reset, then dependent renames
    idle();
    drive(1, 3, 1, 3, 1, 0, 0, 0, 0, 0, 0, 5);
    check("t1_valid", 64'(bus.ren_valid_OUT), 64'(1));
    check("t1_ps_old_map", 64'(bus.ren_ps_OUT), 64'(3));
    check("t1_pd", 64'(bus.ren_pd_OUT), 64'(32));
    check("t1_robIdx", 64'(bus.ren_robIdx_OUT), 64'(5));
    drive(1, 3, 2, 4, 1, 0, 0, 0, 0, 0, 0, 6);
    check("t2_ps_renamed", 64'(bus.ren_ps_OUT), 64'(32));
    check("t2_pd", 64'(bus.ren_pd_OUT), 64'(33));
    check("t2_robIdx", 64'(bus.ren_robIdx_OUT), 64'(6));
    drive(1, 1, 1, 0, 1, 0, 0, 0, 0, 0, 0, 7);
    check("t3_r0_pd", 64'(bus.ren_pd_OUT), 64'(0));
    drive(1, 2, 2, 5, 1, 0, 0, 1, 0, 0, 0, 8);
    check("t4_rob_full_no_ren", 64'(bus.ren_valid_OUT), 64'(0));

    // Drain the free list, then a returned register unblocks the next cycle
    for (int i = 0; i < 30; i++) begin
      drive(1, $urandom_range(0, 31), $urandom_range(0, 31), 1 + (i % 31), 1,
            0, 0, 0, 0, 0, 0, i % 16);
    end
    drive(1, 1, 1, 9, 1, 0, 0, 0, 1, 5, 1, 0);
    check("t5_empty_stall", 64'(bus.ren_valid_OUT), 64'(0));
    drive(1, 1, 1, 10, 1, 0, 0, 0, 0, 0, 0, 1);
    check("t5_freed_pd", 64'(bus.ren_pd_OUT), 64'(5));

    // Flush rewinds the free list to the retirement head
    do_reset();
    drive(1, 0, 0, 3, 1, 0, 0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 5, 1, 0, 0, 0, 0, 0, 0, 1);
    drive(1, 0, 0, 6, 1, 0, 0, 0, 0, 0, 0, 2);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    retrat_m[3] = 32;
    drive(1, 0, 0, 7, 1, 0, 1, 0, 0, 0, 0, 3);
    check("t6_flush_no_ren", 64'(bus.ren_valid_OUT), 64'(0));
    drive(1, 3, 5, 7, 1, 0, 0, 0, 0, 0, 0, 9);
    check("t6_ps_from_retrat", 64'(bus.ren_ps_OUT), 64'(32));
    check("t6_pt_from_retrat", 64'(bus.ren_pt_OUT), 64'(5));
    check("t6_pd_rewound", 64'(bus.ren_pd_OUT), 64'(33));
    drive(1, 7, 0, 8, 1, 1, 0, 0, 0, 0, 0, 10);
    check("t7_freeze_holds_valid", 64'(bus.ren_valid_OUT), 64'(1));
    check("t7_freeze_holds_pd", 64'(bus.ren_pd_OUT), 64'(33));

    // Randomised traffic
    for (int c = 0; c < 3000; c++) begin
      v    = $urandom_range(0, 9) < 7;
      wr   = $urandom_range(0, 9) < 8;
      fz   = $urandom_range(0, 9) == 0;
      fl   = $urandom_range(0, 39) == 0;
      full = $urandom_range(0, 9) == 0;
      cm   = (spq.size() > 0) && ($urandom_range(0, 9) < 3);
      fr   = ((fq.size() + spq.size()) < 32) && ($urandom_range(0, 9) < 3);
      if (fl) begin
        for (int i = 0; i < NA; i++) retrat_m[i] = $urandom_range(0, NP - 1);
      end
      drive(v, $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31), wr,
            fz, fl, full, fr, $urandom_range(1, NP - 1), cm, $urandom_range(0, 15));
    end

    idle();
    check("push_queue_drained", 64'(push_q.size()), 64'(0));
    mon_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

endmodule
